// File: rtl/multicycle_ctrl_pkg.sv
// Shared decode definitions for the RV32I control path.
// Holds the base-opcode and ALU-code enums used by both the single-cycle and
// multi-cycle cores, the multi-cycle controller state enum, and the datapath
// mux-select encodings. No ports; import with multicycle_ctrl_pkg::*.
package multicycle_ctrl_pkg;

  // Base opcode, instr[6:2]; instr[1:0] must be 2'b11 for a 32-bit encoding
  typedef enum logic [4:0] {
    OPC_LOAD   = 5'b00000,
    OPC_OPIMM  = 5'b00100,
    OPC_AUIPC  = 5'b00101,
    OPC_STORE  = 5'b01000,
    OPC_OP     = 5'b01100,
    OPC_LUI    = 5'b01101,
    OPC_BRANCH = 5'b11000,
    OPC_JALR   = 5'b11001,
    OPC_JAL    = 5'b11011
  } opcode_t;

  // ALU operation code, {funct7[5], funct3} layout
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_code_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5,
    TRAP      = 3'd6
  } ctrl_state_t;

  // ALU operand A select
  localparam logic [1:0] ASEL_RS1  = 2'd0;
  localparam logic [1:0] ASEL_PC   = 2'd1;
  localparam logic [1:0] ASEL_ZERO = 2'd2;

  // ALU operand B select
  localparam logic BSEL_RS2 = 1'b0;
  localparam logic BSEL_IMM = 1'b1;

  // Register-file write-back source select
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // True when the 5-bit base opcode is one this core implements
  function automatic logic is_known_opcode(input logic [4:0] opc);
    logic known;
    case (opc)
      OPC_LOAD, OPC_OPIMM, OPC_AUIPC, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL: known = 1'b1;
      default:                                known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_op_decode.sv
// Combinational instruction-class decoder shared by the single- and
// multi-cycle cores.
// Ports:
//   opcode   in  7  instr[6:0]
//   funct3   in  3  instr[14:12]
//   funct7_5 in  1  instr[30]
//   alu_op   out 4  ALU code for OP / OP-IMM, ADD for every other class
//   illegal  out 1  not a 32-bit encoding, or unknown base opcode
module alu_op_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_op,
  output logic       illegal
);

  // ALU code and legality from the opcode fields
  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    if ((opcode[1:0] != 2'b11) || !is_known_opcode(opcode[6:2])) begin
      illegal = 1'b1;
    end else begin
      illegal = 1'b0;
    end
    case (opcode[6:2])
      OPC_OP:    alu_op = {funct7_5, funct3};
      // instr[30] is only an opcode bit for the immediate shifts (SRAI vs
      // SRLI); for every other OP-IMM it belongs to the immediate
      OPC_OPIMM: alu_op = {((funct3 == 3'b101) ? funct7_5 : 1'b0), funct3};
      default:   alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit: decodes the datapath IR and sequences
// FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK with a req/ready handshake
// to a unified instruction/data memory.
// Ports:
//   clk, rst (async, active high), instr (IR), mem_ready, br_taken
//   mem_req/mem_we/mem_addr_sel : memory request, store, address source
//   ir_we, pc_we, pc_sel, jalr_flag : IR / PC update controls
//   alu_op, alu_a_sel, alu_b_sel : ALU operation and operand selects
//   rf_we, wb_sel : register-file write enable and source
//   retire : pulse on an instruction's final cycle
//   illegal : TRAP indication
// Outputs decode from the state and the IR; ir_we, pc_we and retire also
// follow mem_ready / br_taken on the cycle that completes a step.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter bit RESET_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        br_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        jalr_flag,
  output logic [3:0]  alu_op,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        retire,
  output logic        illegal
);

  ctrl_state_t state_r;
  ctrl_state_t next_state_s;
  logic [4:0]  opc_s;
  logic [3:0]  dec_alu_op_s;
  logic        dec_illegal_s;
  logic        unused_instr_s;

  assign opc_s = instr[6:2];
  // Register specifiers and immediates are consumed by the datapath only
  assign unused_instr_s = ^{instr[31], instr[29:15], instr[11:7]};

  alu_op_decode u_alu_op_decode (
    .opcode   (instr[6:0]),
    .funct3   (instr[14:12]),
    .funct7_5 (instr[30]),
    .alu_op   (dec_alu_op_s),
    .illegal  (dec_illegal_s)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and output decode
  always_comb begin
    next_state_s = state_r;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 1'b0;
    jalr_flag    = 1'b0;
    alu_op       = ALU_ADD;
    alu_a_sel    = ASEL_RS1;
    alu_b_sel    = BSEL_RS2;
    rf_we        = 1'b0;
    wb_sel       = WB_ALU;
    retire       = 1'b0;
    illegal      = 1'b0;
    case (state_r)
      IDLE: begin
        next_state_s = FETCH;
      end
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we        = 1'b1;
          next_state_s = DECODE;
        end else begin
          next_state_s = FETCH;
        end
      end
      DECODE: begin
        if (dec_illegal_s) begin
          next_state_s = TRAP;
        end else begin
          next_state_s = EXECUTE;
        end
      end
      EXECUTE: begin
        alu_op = dec_alu_op_s;
        case (opc_s)
          OPC_OP: begin
            next_state_s = WRITEBACK;
          end
          OPC_OPIMM, OPC_JALR: begin
            alu_b_sel    = BSEL_IMM;
            next_state_s = WRITEBACK;
          end
          OPC_LUI: begin
            alu_a_sel    = ASEL_ZERO;
            alu_b_sel    = BSEL_IMM;
            next_state_s = WRITEBACK;
          end
          OPC_AUIPC, OPC_JAL: begin
            alu_a_sel    = ASEL_PC;
            alu_b_sel    = BSEL_IMM;
            next_state_s = WRITEBACK;
          end
          OPC_LOAD, OPC_STORE: begin
            alu_b_sel    = BSEL_IMM;
            next_state_s = MEMORY;
          end
          OPC_BRANCH: begin
            // Taken: PC <= PC+imm from the ALU; not taken: PC <= PC+4
            alu_a_sel    = ASEL_PC;
            alu_b_sel    = BSEL_IMM;
            pc_we        = 1'b1;
            pc_sel       = br_taken;
            retire       = 1'b1;
            next_state_s = FETCH;
          end
          default: begin
            next_state_s = TRAP;
          end
        endcase
      end
      MEMORY: begin
        // IR is stable here, so req/we/addr_sel hold until mem_ready
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (opc_s == OPC_STORE);
        if (mem_ready) begin
          if (opc_s == OPC_STORE) begin
            pc_we        = 1'b1;
            retire       = 1'b1;
            next_state_s = FETCH;
          end else begin
            next_state_s = WRITEBACK;
          end
        end else begin
          next_state_s = MEMORY;
        end
      end
      WRITEBACK: begin
        rf_we        = 1'b1;
        retire       = 1'b1;
        pc_we        = 1'b1;
        next_state_s = FETCH;
        case (opc_s)
          OPC_LOAD: begin
            wb_sel = WB_MEM;
          end
          OPC_JAL: begin
            wb_sel = WB_PC4;
            pc_sel = 1'b1;
          end
          OPC_JALR: begin
            wb_sel    = WB_PC4;
            pc_sel    = 1'b1;
            jalr_flag = 1'b1;
          end
          default: begin
            wb_sel = WB_ALU;
          end
        endcase
      end
      TRAP: begin
        illegal = 1'b1;
        if (RESET_TRAP) begin
          next_state_s = TRAP;
        end else begin
          // Skip the offending word and resume fetching
          pc_we        = 1'b1;
          next_state_s = FETCH;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Two controllers (RESET_TRAP = 1 and 0) run in lockstep on the same inputs.
// Every cycle the stimulus pushes the hand-computed output bundle of each
// instance into a queue; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        mem_ready;
  logic        br_taken;

  logic [1:0]      mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel;
  logic [1:0]      jalr_flag, alu_b_sel, rf_we, retire, illegal;
  logic [1:0][3:0] alu_op;
  logic [1:0][1:0] alu_a_sel, wb_sel;

  multicycle_ctrl #(.RESET_TRAP(1'b1)) dut_trap (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .br_taken(br_taken),
    .mem_req(mem_req[0]), .mem_we(mem_we[0]), .mem_addr_sel(mem_addr_sel[0]),
    .ir_we(ir_we[0]), .pc_we(pc_we[0]), .pc_sel(pc_sel[0]), .jalr_flag(jalr_flag[0]),
    .alu_op(alu_op[0]), .alu_a_sel(alu_a_sel[0]), .alu_b_sel(alu_b_sel[0]),
    .rf_we(rf_we[0]), .wb_sel(wb_sel[0]), .retire(retire[0]), .illegal(illegal[0])
  );

  multicycle_ctrl #(.RESET_TRAP(1'b0)) dut_skip (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .br_taken(br_taken),
    .mem_req(mem_req[1]), .mem_we(mem_we[1]), .mem_addr_sel(mem_addr_sel[1]),
    .ir_we(ir_we[1]), .pc_we(pc_we[1]), .pc_sel(pc_sel[1]), .jalr_flag(jalr_flag[1]),
    .alu_op(alu_op[1]), .alu_a_sel(alu_a_sel[1]), .alu_b_sel(alu_b_sel[1]),
    .rf_we(rf_we[1]), .wb_sel(wb_sel[1]), .retire(retire[1]), .illegal(illegal[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [18:0] e0;
    logic [18:0] e1;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  localparam logic [18:0] Z = 19'h00000;

  // Bundle: req we addr_sel ir_we pc_we pc_sel jalr alu_op[4] a_sel[2] b_sel rf_we wb_sel[2] retire illegal
  function automatic logic [18:0] v(input logic req, input logic we, input logic am,
                                    input logic irwe, input logic pcwe, input logic pcsel,
                                    input logic jalr, input logic [3:0] op, input logic [1:0] as,
                                    input logic bs, input logic rfwe, input logic [1:0] wb,
                                    input logic ret, input logic ill);
    return {req, we, am, irwe, pcwe, pcsel, jalr, op, as, bs, rfwe, wb, ret, ill};
  endfunction

  function automatic logic [18:0] obs(input int i);
    return {mem_req[i], mem_we[i], mem_addr_sel[i], ir_we[i], pc_we[i], pc_sel[i],
            jalr_flag[i], alu_op[i], alu_a_sel[i], alu_b_sel[i], rf_we[i], wb_sel[i],
            retire[i], illegal[i]};
  endfunction

  // Monitor: one expected bundle per instance per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      checks++;
      if (obs(0) !== cur.e0) begin
        errors++;
        $display("FAIL %s [RESET_TRAP=1] t=%0t: got %05h, expected %05h", cur.name, $time, obs(0), cur.e0);
      end
      checks++;
      if (obs(1) !== cur.e1) begin
        errors++;
        $display("FAIL %s [RESET_TRAP=0] t=%0t: got %05h, expected %05h", cur.name, $time, obs(1), cur.e1);
      end
    end
  end

  task automatic cyc2(input string nm, input logic rdy, input logic bt,
                      input logic [18:0] e0, input logic [18:0] e1);
    @(posedge clk); #1;
    mem_ready = rdy;
    br_taken  = bt;
    exp_q.push_back('{nm, e0, e1});
  endtask

  task automatic cyc(input string nm, input logic rdy, input logic bt, input logic [18:0] e);
    cyc2(nm, rdy, bt, e, e);
  endtask

  // FETCH with 'waits' not-ready cycles; the IR changes only once FETCH starts
  task automatic fetch(input string nm, input logic [31:0] word, input int waits);
    for (int k = 0; k <= waits; k++) begin
      @(posedge clk); #1;
      if (k == 0) instr = word;
      mem_ready = (k == waits);
      br_taken  = 1'b0;
      exp_q.push_back('{nm, v(1'b1, 1'b0, 1'b0, (k == waits), 1'b0, 1'b0, 1'b0, 4'd0, 2'd0,
                              1'b0, 1'b0, 2'd0, 1'b0, 1'b0),
                            v(1'b1, 1'b0, 1'b0, (k == waits), 1'b0, 1'b0, 1'b0, 4'd0, 2'd0,
                              1'b0, 1'b0, 2'd0, 1'b0, 1'b0)});
    end
  endtask

  // mem_ready is held high outside requests to show it is ignored there
  task automatic decode(input string nm);
    cyc(nm, 1'b1, 1'b0, Z);
  endtask

  task automatic exec(input string nm, input logic [3:0] op, input logic [1:0] as, input logic bs);
    cyc(nm, 1'b1, 1'b0, v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, op, as, bs, 1'b0, 2'd0, 1'b0, 1'b0));
  endtask

  task automatic wb(input string nm, input logic [1:0] wsel, input logic pcsel, input logic jalr);
    cyc(nm, 1'b1, 1'b0, v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, pcsel, jalr, 4'd0, 2'd0, 1'b0, 1'b1, wsel, 1'b1, 1'b0));
  endtask

  task automatic mem(input string nm, input logic we, input int waits);
    for (int k = 0; k < waits; k++)
      cyc(nm, 1'b0, 1'b0, v(1'b1, we, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0));
    cyc(nm, 1'b1, 1'b0, v(1'b1, we, 1'b1, 1'b0, we, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 2'd0, we, 1'b0));
  endtask

  task automatic branch(input string nm, input logic bt);
    cyc(nm, 1'b1, bt, v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, bt, 1'b0, 4'd0, 2'd1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0));
  endtask

  // Assert rst just after a clock edge: outputs must be zero in that cycle
  task automatic rst_mid(input string nm);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    #1 rst = 1'b1;
    exp_q.push_back('{nm, Z, Z});
  endtask

  task automatic rst_release(input string nm);
    @(posedge clk); #1;
    rst       = 1'b0;
    mem_ready = 1'b0;
    exp_q.push_back('{nm, Z, Z});
  endtask

  initial begin
    rst       = 1'b1;
    instr     = 32'h0000_0000;
    mem_ready = 1'b0;
    br_taken  = 1'b0;
    cyc("reset", 1'b1, 1'b0, Z);
    cyc("reset", 1'b1, 1'b0, Z);
    rst_release("idle_after_reset");

    fetch("add_fetch", 32'h002081B3, 0); decode("add_dec");
    exec("add_ex", 4'b0000, 2'd0, 1'b0);  wb("add_wb", 2'd0, 1'b0, 1'b0);

    fetch("srai_fetch", 32'h4030D093, 0); decode("srai_dec");
    exec("srai_ex", 4'b1101, 2'd0, 1'b1); wb("srai_wb", 2'd0, 1'b0, 1'b0);

    fetch("srli_fetch", 32'h0030D093, 0); decode("srli_dec");
    exec("srli_ex", 4'b0101, 2'd0, 1'b1); wb("srli_wb", 2'd0, 1'b0, 1'b0);

    fetch("sub_fetch", 32'h402081B3, 0);  decode("sub_dec");
    exec("sub_ex", 4'b1000, 2'd0, 1'b0);  wb("sub_wb", 2'd0, 1'b0, 1'b0);

    fetch("xor_fetch", 32'h0020C1B3, 0);  decode("xor_dec");
    exec("xor_ex", 4'b0100, 2'd0, 1'b0);  wb("xor_wb", 2'd0, 1'b0, 1'b0);

    // ADDI with imm bit 10 set: instr[30] must not leak into alu_op
    fetch("addi_fetch", 32'h40008093, 0); decode("addi_dec");
    exec("addi_ex", 4'b0000, 2'd0, 1'b1); wb("addi_wb", 2'd0, 1'b0, 1'b0);

    fetch("lui_fetch", 32'h123450B7, 0);  decode("lui_dec");
    exec("lui_ex", 4'b0000, 2'd2, 1'b1);  wb("lui_wb", 2'd0, 1'b0, 1'b0);

    fetch("auipc_fetch", 32'h00000097, 2); decode("auipc_dec");
    exec("auipc_ex", 4'b0000, 2'd1, 1'b1); wb("auipc_wb", 2'd0, 1'b0, 1'b0);

    fetch("jal_fetch", 32'h008000EF, 0);  decode("jal_dec");
    exec("jal_ex", 4'b0000, 2'd1, 1'b1);  wb("jal_wb", 2'd2, 1'b1, 1'b0);

    fetch("jalr_fetch", 32'h000080E7, 0); decode("jalr_dec");
    exec("jalr_ex", 4'b0000, 2'd0, 1'b1); wb("jalr_wb", 2'd2, 1'b1, 1'b1);

    fetch("lw_fetch", 32'h0000A183, 0);   decode("lw_dec");
    exec("lw_ex", 4'b0000, 2'd0, 1'b1);   mem("lw_mem", 1'b0, 3);
    wb("lw_wb", 2'd1, 1'b0, 1'b0);

    fetch("sw_fetch", 32'h0020A023, 0);   decode("sw_dec");
    exec("sw_ex", 4'b0000, 2'd0, 1'b1);   mem("sw_mem", 1'b1, 1);

    fetch("beq_t_fetch", 32'h00208463, 0); decode("beq_t_dec"); branch("beq_taken_ex", 1'b1);
    fetch("beq_n_fetch", 32'h00208463, 0); decode("beq_n_dec"); branch("beq_not_taken_ex", 1'b0);

    // Illegal word: trap holds vs. one-cycle pulse then FETCH (memory stalls)
    fetch("ill_fetch", 32'hFFFFFFFF, 0);  decode("ill_dec");
    cyc2("ill_trap", 1'b0, 1'b0,
         v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1),
         v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1));
    for (int k = 0; k < 3; k++)
      cyc2("ill_after", 1'b0, 1'b0,
           v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1),
           v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0));
    rst_mid("trap_rst");
    cyc("trap_rst_hold", 1'b0, 1'b0, Z);
    rst_release("idle_after_trap_rst");

    // Reset in the middle of a load's memory wait
    fetch("lw2_fetch", 32'h0000A183, 0);  decode("lw2_dec");
    exec("lw2_ex", 4'b0000, 2'd0, 1'b1);
    for (int k = 0; k < 2; k++)
      cyc("lw2_mem_wait", 1'b0, 1'b0,
          v(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0));
    rst_mid("lw2_rst_async");
    cyc("lw2_rst_hold", 1'b1, 1'b0, Z);
    rst_release("idle_after_lw2_rst");
    fetch("post_rst_fetch", 32'h002081B3, 1); decode("post_rst_dec");
    exec("post_rst_ex", 4'b0000, 2'd0, 1'b0); wb("post_rst_wb", 2'd0, 1'b0, 1'b0);

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected bundles never compared, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
